// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, single-outstanding imem handshake and IF/ID register.
// Optional `IF_PERF_EN adds bubble/flush event counters.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IFWrite,
    input  logic        Branch,
    input  logic        Jump,
    input  logic [31:0] JumpAddr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] Instruction_id,
    output logic [31:0] PC_id
`ifdef IF_PERF_EN
    ,
    output logic [31:0] perf_bubble_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

    state_t      state, state_next;
    logic [31:0] pc_if, pc_if_next;
    logic [31:0] instr_next, pc_id_next;
    logic [31:0] skid, skid_next;
    logic [31:0] target, target_next;
    logic        redirect;
    logic        load_nop;

    // Redirects resolved in ID are only trusted when ID itself is advancing.
    assign redirect  = (Branch | Jump) & IFWrite;
    assign imem_addr = pc_if;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            FETCH: begin
                if (imem_valid) begin
                    if (!redirect && !IFWrite) state_next = HOLD;
                end else if (redirect) begin
                    state_next = DISCARD;
                end
            end
            HOLD:    if (redirect || IFWrite) state_next = FETCH;
            DISCARD: if (imem_valid) state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        imem_req    = !reset && (state != HOLD);
        pc_if_next  = pc_if;
        instr_next  = Instruction_id;
        pc_id_next  = PC_id;
        skid_next   = skid;
        target_next = target;
        load_nop    = 1'b0;
        case (state)
            FETCH: begin
                if (imem_valid) begin
                    if (redirect) begin
                        load_nop   = 1'b1;
                        pc_if_next = JumpAddr;
                    end else if (IFWrite) begin
                        instr_next = imem_rdata;
                        pc_id_next = pc_if;
                        pc_if_next = pc_if + 32'd4;
                    end else begin
                        skid_next = imem_rdata;
                    end
                end else if (redirect) begin
                    load_nop    = 1'b1;
                    target_next = JumpAddr;
                end else if (IFWrite) begin
                    load_nop = 1'b1;
                end
            end
            HOLD: begin
                if (redirect) begin
                    load_nop   = 1'b1;
                    pc_if_next = JumpAddr;
                end else if (IFWrite) begin
                    instr_next = skid;
                    pc_id_next = pc_if;
                    pc_if_next = pc_if + 32'd4;
                end
            end
            DISCARD: begin
                // The stale response is dropped; the newest redirect target wins.
                if (IFWrite)  load_nop    = 1'b1;
                if (redirect) target_next = JumpAddr;
                if (imem_valid) pc_if_next = redirect ? JumpAddr : target;
            end
            default: ;
        endcase
        if (load_nop) instr_next = NOP_INSTR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_if          <= RESET_PC;
            Instruction_id <= NOP_INSTR;
            PC_id          <= 32'h0;
            skid           <= 32'h0;
            target         <= 32'h0;
        end else begin
            pc_if          <= pc_if_next;
            Instruction_id <= instr_next;
            PC_id          <= pc_id_next;
            skid           <= skid_next;
            target         <= target_next;
        end
    end

`ifdef IF_PERF_EN
    // load_nop only fires with IFWrite=1, so it is exactly the bubble event.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_bubble_cnt <= 32'h0;
            perf_flush_cnt  <= 32'h0;
        end else begin
            perf_bubble_cnt <= perf_bubble_cnt + {31'h0, load_nop};
            perf_flush_cnt  <= perf_flush_cnt + {31'h0, redirect};
        end
    end
`endif

endmodule
